user_obi_dma: RTL and testbench

Single-channel word-copy engine acting as an OBI manager in the user domain, the initiator-side counterpart to the user-domain subordinates (user ROM at 0x2000_0000 and any later additions). Software or a controller supplies source address, destination address and word count, then pulses start. The block reads each 32-bit word over its OBI manager port and writes it back, one transaction outstanding at a time. It reports completion, progress and bus errors.

---
 rtl/user_obi_dma.sv | 136 +++++++++++++
 tb/tb_user_obi_dma.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_obi_dma.sv
// rtl/user_obi_dma.sv - single-channel OBI word-copy engine
// Reads one word at a time from the source, writes it to the destination, and stops on the first bus error.
module user_obi_dma #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_addr_i,
  input  logic [AddrWidth-1:0] dst_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [LenWidth-1:0]  words_done_o,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic                 obi_we_o,
  output logic [3:0]           obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  input  logic                 obi_rvalid_i,
  input  logic [DataWidth-1:0] obi_rdata_i,
  input  logic                 obi_err_i
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH} state_e;

  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(3);
  localparam logic [AddrWidth-1:0] WordStep  = AddrWidth'(4);

  state_e               state;
  logic [AddrWidth-1:0] src_ptr;
  logic [AddrWidth-1:0] dst_ptr;
  logic [LenWidth-1:0]  len_q;

  assign obi_be_o = 4'hF;

  // obi_wdata_o doubles as the data register: it holds the word between read and write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      len_q        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      words_done_o <= '0;
      obi_req_o    <= 1'b0;
      obi_we_o     <= 1'b0;
      obi_addr_o   <= '0;
      obi_wdata_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            src_ptr      <= src_addr_i & AlignMask;
            dst_ptr      <= dst_addr_i & AlignMask;
            len_q        <= len_i;
            error_o      <= 1'b0;
            words_done_o <= '0;
            busy_o       <= 1'b1;
            if (len_i == '0) begin
              state  <= FINISH;
              done_o <= 1'b1;
            end else begin
              state      <= RD_REQ;
              obi_req_o  <= 1'b1;
              obi_we_o   <= 1'b0;
              obi_addr_o <= src_addr_i & AlignMask;
            end
          end
        end
        RD_REQ: begin
          if (obi_gnt_i) begin
            obi_req_o <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (obi_rvalid_i) begin
            if (obi_err_i) begin
              error_o <= 1'b1;
              done_o  <= 1'b1;
              state   <= FINISH;
            end else begin
              obi_wdata_o <= obi_rdata_i;
              obi_req_o   <= 1'b1;
              obi_we_o    <= 1'b1;
              obi_addr_o  <= dst_ptr;
              state       <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (obi_gnt_i) begin
            obi_req_o <= 1'b0;
            state     <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (obi_rvalid_i) begin
            if (obi_err_i) begin
              error_o <= 1'b1;
              done_o  <= 1'b1;
              state   <= FINISH;
            end else begin
              words_done_o <= words_done_o + LenWidth'(1);
              src_ptr      <= src_ptr + WordStep;
              dst_ptr      <= dst_ptr + WordStep;
              if (words_done_o + LenWidth'(1) == len_q) begin
                done_o <= 1'b1;
                state  <= FINISH;
              end else begin
                obi_req_o  <= 1'b1;
                obi_we_o   <= 1'b0;
                obi_addr_o <= src_ptr + WordStep;
                state      <= RD_REQ;
              end
            end
          end
        end
        FINISH: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_obi_dma.sv
// tb/tb_user_obi_dma.sv - scoreboard bench for user_obi_dma
// A bus model answers requests; a monitor compares handshakes and done pulses against queued expectations.
module tb_user_obi_dma;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    int   words;
    logic err;
    int   cyc;
  } done_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_done;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  bus_t  exp_bus[$];
  done_t exp_done[$];
  int    n_pass;
  int    n_total;
  int    cyc;

  int          max_stall;
  int          err_read;
  int          rd_cnt;
  int          gnt_wait;
  int          rsp_wait;
  logic        pend;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int          outstanding;
  logic        hold_v;
  logic [31:0] hold_addr;
  logic        hold_we;
  logic [31:0] hold_wdata;

  user_obi_dma dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .src_addr_i  (src_addr),
    .dst_addr_i  (dst_addr),
    .len_i       (len_in),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .words_done_o(words_done),
    .obi_req_o   (req),
    .obi_gnt_i   (gnt),
    .obi_addr_o  (addr),
    .obi_we_o    (we),
    .obi_be_o    (be),
    .obi_wdata_o (wdata),
    .obi_rvalid_i(rvalid),
    .obi_rdata_i (rdata),
    .obi_err_i   (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: event not expected", name);
  endtask

  // Memory model: read data is a pure function of the address.
  assign gnt = req && (gnt_wait == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_wait <= 0;
      rsp_wait <= 0;
      pend     <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      err      <= 1'b0;
      rd_cnt   <= 0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      if (start && !busy) rd_cnt <= 0;
      if (req && !gnt && gnt_wait != 0) gnt_wait <= gnt_wait - 1;
      if (req && gnt) begin
        gnt_wait <= $urandom_range(max_stall, 0);
        if (!we) rd_cnt <= rd_cnt + 1;
        if (max_stall == 0) begin
          rvalid <= 1'b1;
          rdata  <= we ? 32'h0 : rd_word(addr);
          err    <= !we && (rd_cnt == err_read);
        end else begin
          pend     <= 1'b1;
          rsp_wait <= $urandom_range(max_stall, 0);
          rsp_data <= we ? 32'h0 : rd_word(addr);
          rsp_err  <= !we && (rd_cnt == err_read);
        end
      end else if (pend) begin
        if (rsp_wait == 0) begin
          rvalid <= 1'b1;
          rdata  <= rsp_data;
          err    <= rsp_err;
          pend   <= 1'b0;
        end else begin
          rsp_wait <= rsp_wait - 1;
        end
      end
    end
  end

  initial begin
    bus_t  eb;
    done_t ed;
    outstanding = 0;
    hold_v      = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0;
        hold_v      = 1'b0;
      end else begin
        if (hold_v) begin
          check("req_held", req, 1);
          check("addr_stable", addr, hold_addr);
          check("we_stable", we, hold_we);
          check("wdata_stable", wdata, hold_wdata);
        end
        if (rvalid) outstanding--;
        if (req && gnt) begin
          check("one_outstanding", outstanding, 0);
          check("be", be, 4'hF);
          if (exp_bus.size() == 0) fail("bus_unexpected");
          else begin
            eb = exp_bus.pop_front();
            check("bus_we", we, eb.we);
            check("bus_addr", addr, eb.addr);
            if (eb.we) check("bus_wdata", wdata, eb.data);
          end
          outstanding++;
        end
        hold_v     = req && !gnt;
        hold_addr  = addr;
        hold_we    = we;
        hold_wdata = wdata;
        if (done) begin
          if (exp_done.size() == 0) fail("done_unexpected");
          else begin
            ed = exp_done.pop_front();
            check("done_words", words_done, 16'(ed.words));
            check("done_error", error, ed.err);
            check("done_busy", busy, 1);
            if (ed.cyc >= 0) check("done_cycle", cyc, ed.cyc);
          end
        end
      end
    end
  end

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                         input int stall, input int err_idx);
    logic [31:0] sa;
    logic [31:0] da;
    logic        jerr;
    int          words;
    int          n;
    sa    = src & 32'hFFFF_FFFC;
    da    = dst & 32'hFFFF_FFFC;
    jerr  = (err_idx >= 0) && (err_idx < len);
    words = jerr ? err_idx : len;
    max_stall = stall;
    err_read  = err_idx;
    for (int i = 0; i < len; i++) begin
      exp_bus.push_back('{1'b0, sa + 32'(4 * i), 32'h0});
      if (jerr && i == err_idx) break;
      exp_bus.push_back('{1'b1, da + 32'(4 * i), rd_word(sa + 32'(4 * i))});
    end
    n = cyc + 1;
    exp_done.push_back('{words, jerr, (stall != 0) ? -1 : (jerr ? n + 4 * err_idx + 2 : n + 4 * len)});
    src_addr = src;
    dst_addr = dst;
    len_in   = 16'(len);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("error_cleared", error, 0);
    check("words_cleared", words_done, 0);
    for (int t = 0; t < 4000 && !done; t++) @(negedge clk);
    check("done_seen", done, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("final_words", words_done, 16'(words));
    check("final_error", error, jerr);
    check("bus_queue_empty", exp_bus.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    len_in    = '0;
    max_stall = 0;
    err_read  = -1;
    n_pass    = 0;
    n_total   = 0;
    cyc       = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_done, 0);
    check("rst_req", req, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_be", be, 4'hF);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(32'h2000_0000, 32'h1000_0100, 4, 0, -1);
    run_job(32'h2000_1000, 32'h1000_2000, 32, 5, -1);
    run_job(32'h2000_0040, 32'h1000_0040, 0, 0, -1);
    run_job(32'h2000_0200, 32'h1000_0300, 8, 0, 2);
    run_job(32'h2000_0400, 32'h1000_0400, 1, 0, -1);
    run_job(32'hFFFF_FFFC, 32'h0000_2003, 2, 0, -1);

    // Extra starts while busy must not disturb the job; reset lands during the second write.
    max_stall = 0;
    err_read  = -1;
    exp_bus.push_back('{1'b0, 32'h3000_0000, 32'h0});
    exp_bus.push_back('{1'b1, 32'h4000_0000, rd_word(32'h3000_0000)});
    exp_bus.push_back('{1'b0, 32'h3000_0004, 32'h0});
    exp_bus.push_back('{1'b1, 32'h4000_0004, rd_word(32'h3000_0004)});
    src_addr = 32'h3000_0000;
    dst_addr = 32'h4000_0000;
    len_in   = 16'd4;
    start    = 1'b1;
    @(negedge clk);
    src_addr = 32'h5000_0000;
    dst_addr = 32'h6000_0000;
    len_in   = 16'd7;
    repeat (3) @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 100 && !(req && we && addr == 32'h4000_0004); t++) @(negedge clk);
    check("second_write_reached", {req, we}, 2'b11);
    check("words_before_reset", words_done, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_words", words_done, 0);
    check("rst_mid_addr", addr, 0);
    check("rst_mid_we", we, 0);
    exp_bus.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(32'h2000_0800, 32'h1000_0800, 2, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
